// File: rtl/unified_cache_port_queue_if.sv
// Client/cache side bundle of the unified cache port queue.
// The client (or bench) uses the master view; the queue uses the slave view.
interface unified_cache_port_queue_if #(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 64,
    parameter int PTR_WIDTH                          = 2
);
    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_packet_in;
    logic                                          request_packet_ack_out;
    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] cache_packet_out;
    logic                                          cache_packet_ack_in;
    logic [PTR_WIDTH:0]                            occupancy_out;
    logic                                          full_out;
    logic                                          empty_out;

    modport master (
        output request_packet_in,
        output cache_packet_ack_in,
        input  request_packet_ack_out,
        input  cache_packet_out,
        input  occupancy_out,
        input  full_out,
        input  empty_out
    );

    modport slave (
        input  request_packet_in,
        input  cache_packet_ack_in,
        output request_packet_ack_out,
        output cache_packet_out,
        output occupancy_out,
        output full_out,
        output empty_out
    );
endinterface

// File: rtl/unified_cache_port_queue.sv
// In-order request buffer between one client and one unified cache input slice.
// Accepts valid packets while not full and re-presents the head until the cache acks it.
module unified_cache_port_queue #(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 64,
    parameter int UNIFIED_CACHE_PACKET_VALID_POS     = 63,
    parameter int DEPTH                              = 4,
    parameter int PTR_WIDTH                          = $clog2(DEPTH)
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    unified_cache_port_queue_if.slave      bus
);
    localparam int W = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;

    logic [W-1:0]         r_entry [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == (PTR_WIDTH+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Push looks only at the registered full flag, so a same-cycle pop never frees a slot early.
    assign w_push = bus.request_packet_in[UNIFIED_CACHE_PACKET_VALID_POS] & ~w_full;
    assign w_pop  = bus.cache_packet_ack_in & ~w_empty;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (PTR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents need no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_entry[r_wr_ptr] <= bus.request_packet_in;
        end
    end

    assign bus.request_packet_ack_out = w_push;
    assign bus.cache_packet_out       = w_empty ? '0 : r_entry[r_rd_ptr];
    assign bus.occupancy_out          = r_count;
    assign bus.full_out               = w_full;
    assign bus.empty_out              = w_empty;

    a_count_bounded: assert property (@(posedge clk_in) disable iff (reset_in)
        r_count <= (PTR_WIDTH+1)'(DEPTH));

    a_ack_needs_valid: assert property (@(posedge clk_in) disable iff (reset_in)
        bus.request_packet_ack_out |-> bus.request_packet_in[UNIFIED_CACHE_PACKET_VALID_POS]);
endmodule

// File: tb/tb_unified_cache_port_queue.sv
// Bench for unified_cache_port_queue: directed scenarios plus random traffic,
// checked by a queue-based reference model and an independent head monitor.
module tb_unified_cache_port_queue;
    localparam int W     = 64;
    localparam int VP    = 63;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH);

    logic clk_in;
    logic reset_in;

    unified_cache_port_queue_if #(
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(W),
        .PTR_WIDTH(PW)
    ) bus ();

    unified_cache_port_queue #(
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(W),
        .UNIFIED_CACHE_PACKET_VALID_POS(VP),
        .DEPTH(DEPTH),
        .PTR_WIDTH(PW)
    ) dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    int           model_count = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit v, input logic [31:0] addr);
        logic [W-1:0] p;
        p        = {$urandom, $urandom};
        p[VP]    = v;
        p[31:0]  = addr;
        return p;
    endfunction

    // Reference model: ack is predicted purely from how many packets the model holds.
    initial begin
        logic         exp_ack;
        logic         exp_pop;
        logic [W-1:0] pkt;
        forever begin
            @(negedge clk_in);
            if (reset_in) begin
                model_count = 0;
                exp_q.delete();
            end else begin
                pkt     = bus.request_packet_in;
                exp_ack = pkt[VP] && (model_count < DEPTH);
                exp_pop = bus.cache_packet_ack_in && (model_count > 0);
                chk("ack_out",   W'(bus.request_packet_ack_out), W'(exp_ack));
                chk("occupancy", W'(bus.occupancy_out),          W'(model_count));
                chk("full",      W'(bus.full_out),               W'(model_count == DEPTH));
                chk("empty",     W'(bus.empty_out),              W'(model_count == 0));
                #1;
                if (reset_in) begin
                    model_count = 0;
                    exp_q.delete();
                end else begin
                    if (exp_ack) exp_q.push_back(pkt);
                    model_count = model_count + int'(exp_ack) - int'(exp_pop);
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the expected FIFO order.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!reset_in) begin
                if (bus.empty_out) begin
                    chk("idle_zero", bus.cache_packet_out, '0);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_unexpected: got %h expected none", bus.cache_packet_out);
                end else begin
                    chk("head", bus.cache_packet_out, exp_q[0]);
                    if (bus.cache_packet_ack_in) begin
                        $display("deliver addr=%h pkt=%h", exp_q[0][31:0], exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push_pkt(input logic [31:0] addr);
        bit got;
        got = 1'b0;
        bus.request_packet_in = mk(1'b1, addr);
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk_in);
            got = bus.request_packet_ack_out;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no ack expected ack for addr %h", addr);
        end
        @(posedge clk_in);
        #1;
        bus.request_packet_in = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ack"},   W'(bus.request_packet_ack_out), '0);
        chk({tag, "_pkt"},   bus.cache_packet_out,           '0);
        chk({tag, "_occ"},   W'(bus.occupancy_out),          '0);
        chk({tag, "_full"},  W'(bus.full_out),               '0);
        chk({tag, "_empty"}, W'(bus.empty_out),              W'(1));
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        check_reset_values(tag);
        @(negedge clk_in);
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
    endtask

    initial begin
        bit acc;
        reset_in                = 1'b1;
        bus.request_packet_in   = '0;
        bus.cache_packet_ack_in = 1'b0;
        #1;
        check_reset_values("por");
        cyc(3);
        reset_in = 1'b0;
        cyc(2);

        // Single request, acked by the cache two cycles after it appears.
        push_pkt(32'h100);
        cyc(1);
        bus.cache_packet_ack_in = 1'b1;
        cyc(1);
        bus.cache_packet_ack_in = 1'b0;
        cyc(2);

        // Fill to full, then a fifth packet that must wait.
        push_pkt(32'h0);
        push_pkt(32'h40);
        push_pkt(32'h80);
        push_pkt(32'hC0);
        bus.request_packet_in = mk(1'b1, 32'h100);
        cyc(2);
        bus.cache_packet_ack_in = 1'b1;
        cyc(1);
        bus.cache_packet_ack_in = 1'b0;
        cyc(1);
        bus.request_packet_in   = '0;
        bus.cache_packet_ack_in = 1'b1;
        cyc(6);

        // Streaming with the cache always ready; pointers wrap several times.
        for (int i = 0; i < 10; i++) push_pkt(32'h1000 + 32'(i) * 32'h40);
        cyc(2);
        bus.cache_packet_ack_in = 1'b0;

        // Invalid packets and spurious cache acks while empty.
        bus.request_packet_in = mk(1'b0, 32'hDEAD);
        cyc(3);
        bus.request_packet_in   = '0;
        bus.cache_packet_ack_in = 1'b1;
        cyc(3);
        bus.cache_packet_ack_in = 1'b0;

        // Reset with three queued, then the first new push must be the head.
        push_pkt(32'h200);
        push_pkt(32'h240);
        push_pkt(32'h280);
        async_reset("midrst");
        push_pkt(32'hABC);
        cyc(2);
        bus.cache_packet_ack_in = 1'b1;
        cyc(2);

        // Random traffic: light cache acking first (queue fills), heavy later.
        bus.request_packet_in = '0;
        acc = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!bus.request_packet_in[VP] || acc) begin
                bus.request_packet_in = mk($urandom_range(0, 4) != 0, $urandom);
            end
            bus.cache_packet_ack_in = ($urandom_range(0, 99) < ((c < 400) ? 30 : 75));
            @(negedge clk_in);
            acc = bus.request_packet_ack_out;
            @(posedge clk_in);
            #1;
        end
        bus.request_packet_in   = '0;
        bus.cache_packet_ack_in = 1'b1;
        cyc(DEPTH + 2);
        bus.cache_packet_ack_in = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unified_cache_port_queue.md
# unified_cache_port_queue

Per-port request buffer between a requesting client (fetch unit, load/store unit) and one slice of the unified cache's `input_packet_flatted_in` / `input_packet_ack_flatted_out` pair. Accepts cache packets under the codebase's valid-bit/ack handshake, holds up to DEPTH of them in order, and re-presents the head packet to the cache until the cache acks it. Decouples client stalls from cache arbitration, so a client can post several requests while the cache is busy with memory traffic.

## Interface
Parameters:
- UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, width of one cache packet.
- DEPTH, 4, number of packet entries; power of two, at least 2.
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width.

Ports:
- clk_in  input  1  single clock.
- reset_in  input  1  asynchronous, active-high reset.
- request_packet_in  input  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  client packet; valid when bit `UNIFIED_CACHE_PACKET_VALID_POS` is 1.
- request_packet_ack_out  output  1  packet on request_packet_in accepted this cycle.
- cache_packet_out  output  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  head packet to cache; all zeros when empty.
- cache_packet_ack_in  input  1  cache has taken cache_packet_out this cycle.
- occupancy_out  output  PTR_WIDTH+1  entries currently held, 0..DEPTH.
- full_out  output  1  occupancy_out == DEPTH.
- empty_out  output  1  occupancy_out == 0.

## Operation
- Storage: DEPTH packet registers, write pointer wr_ptr, read pointer rd_ptr (PTR_WIDTH bits, wrap modulo DEPTH naturally), count register (PTR_WIDTH+1 bits).
- Push: push = request_packet_in[VALID_POS] & ~full_out. request_packet_ack_out = push (combinational; no dependence on cache_packet_ack_in). On push, entry[wr_ptr] <= request_packet_in, wr_ptr <= wr_ptr+1.
- Packets with valid bit 0 are ignored; never acked, never stored.
- Client holds its packet until it sees ack; packet is captured exactly once, on the ack cycle.
- Pop: pop = cache_packet_ack_in & ~empty_out. On pop, rd_ptr <= rd_ptr+1. cache_packet_ack_in while empty is ignored.
- cache_packet_out = empty_out ? 0 : entry[rd_ptr]; valid bit therefore tracks ~empty_out.
- Count: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
- Full: push blocked even if pop occurs in the same cycle (no ack_in -> ack_out path); the slot frees next cycle.
- Empty with simultaneous push: packet not forwarded same cycle (no bypass); appears next cycle.
- Order strictly FIFO; packet contents (address, type, mask, port number, data) passed unmodified.
- Reset mid-operation: all queued packets discarded, pointers and count to 0; no ack issued in reset.

## Timing
- Reset values: request_packet_ack_out 0 (valid in held 0), cache_packet_out 0, occupancy_out 0, full_out 0, empty_out 1; entry contents don't care.
- Push-to-present latency: packet acked in cycle N is on cache_packet_out in cycle N+1 if queue was empty.
- Pop: head advances at edge ending the ack cycle; next entry visible in the following cycle; back-to-back acks drain one packet per cycle.
- Sustained throughput: one push and one pop per cycle when 0 < occupancy < DEPTH.
- full_out, empty_out, occupancy_out derived from the count register; all registered-state outputs, no combinational input dependence.

## Test plan
- Reset then idle: reset_in pulsed mid-clock with no clock edge -> outputs go to reset values immediately; empty_out=1, occupancy_out=0, cache_packet_out=0.
- Single request: valid packet addr 0x100 presented cycle 0 -> ack_out=1 in cycle 0; cache_packet_out=addr 0x100 with valid bit 1 in cycle 1; ack_in in cycle 3 -> empty_out=1 and cache_packet_out=0 in cycle 4.
- Fill to full (DEPTH=4): four packets addr 0x0,0x40,0x80,0xC0 pushed back-to-back with ack_in=0 -> occupancy 1,2,3,4; fifth packet 0x100 held with ack_out=0; full_out=1.
- Full with simultaneous pop: full queue, ack_in=1 and fifth packet valid in same cycle -> ack_out=0 that cycle, occupancy 3; next cycle ack_out=1, occupancy back to 4; drain yields order 0x40,0x80,0xC0,0x100.
- Streaming wrap-around: 10 packets pushed while ack_in held 1 -> cache receives all 10 in order, occupancy never exceeds 1, pointers wrap past 3 correctly.
- Invalid and spurious inputs: packet with valid bit 0 -> no ack, occupancy unchanged; ack_in=1 while empty -> no pointer change; reset asserted with 3 queued -> empty_out=1, first post-reset push appears at head.
